// File: rtl/adder_share_sequencer.sv
// Shares one SLICE_W-bit adder slice between two requesters, rippling the carry
// through NSLICE passes to form a full-width sum with round-robin arbitration.
module adder_share_sequencer #(
  parameter int unsigned SLICE_W = 4,
  parameter int unsigned NSLICE  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        req0_valid,
  output logic                        req0_ready,
  input  logic [SLICE_W*NSLICE-1:0]   req0_a,
  input  logic [SLICE_W*NSLICE-1:0]   req0_b,
  input  logic                        req1_valid,
  output logic                        req1_ready,
  input  logic [SLICE_W*NSLICE-1:0]   req1_a,
  input  logic [SLICE_W*NSLICE-1:0]   req1_b,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_id,
  output logic [SLICE_W*NSLICE-1:0]   rsp_sum,
  output logic                        rsp_cout
);

  localparam int unsigned W  = SLICE_W * NSLICE;
  localparam int unsigned IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t             state, state_nxt;
  logic               ptr;
  logic               grant0, grant1, accept, id_sel;
  logic [W-1:0]       a_q, b_q, work, work_nxt;
  logic               id_q;
  logic [IW-1:0]      idx;
  logic               carry;
  logic [SLICE_W-1:0] a_sl, b_sl, s;
  logic               c;

  always_comb begin
    grant0     = req0_valid & (~req1_valid | ~ptr);
    grant1     = req1_valid & (~req0_valid | ptr);
    req0_ready = (state == IDLE) & grant0 & ~rst;
    req1_ready = (state == IDLE) & grant1 & ~rst;
    accept     = req0_ready | req1_ready;
    id_sel     = req1_ready;
  end

  // The slice result is merged into a working copy; rsp_sum only updates on the last pass.
  always_comb begin
    a_sl     = a_q[idx*SLICE_W +: SLICE_W];
    b_sl     = b_q[idx*SLICE_W +: SLICE_W];
    {c, s}   = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE_W+1)'(carry);
    work_nxt = work;
    work_nxt[idx*SLICE_W +: SLICE_W] = s;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ADD;
      ADD:     if (idx == LAST) state_nxt = DONE;
      DONE:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr      <= 1'b0;
      idx      <= '0;
      carry    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      work     <= '0;
      rsp_sum  <= '0;
      rsp_cout <= 1'b0;
      rsp_id   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_q   <= id_sel ? req1_a : req0_a;
            b_q   <= id_sel ? req1_b : req0_b;
            id_q  <= id_sel;
            ptr   <= ~id_sel;
            carry <= 1'b0;
            idx   <= '0;
            work  <= '0;
          end
        end
        ADD: begin
          carry <= c;
          work  <= work_nxt;
          if (idx == LAST) begin
            rsp_sum  <= work_nxt;
            rsp_cout <= c;
            rsp_id   <= id_q;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (state == DONE);

endmodule
